// File: rtl/wb_dual_master_arbiter.sv
// Purpose: round-robin share of one Wishbone-classic slave port between an
//          instruction-fetch master (m0) and a load/store master (m1).
// Latency: request -> s_stb_o after 1 edge; slave ack -> mN_ack_o after 1 edge;
//          3 cycles per transfer minimum (IDLE, BUSY, ACK), one transfer in flight.
// Backpressure: the losing master simply keeps its request up; the slave stalls
//          by withholding s_ack_i, and the arbiter holds all s_* outputs meanwhile.
//
// Ports
//   sys_clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   mN_cyc/stb/we/sel/addr/data_i   master N request (N = 0 fetch, 1 load/store)
//   mN_data_o, mN_ack_o     master N read data and single-cycle ack
//   s_cyc/stb/we/sel/addr/data_o    registered slave request
//   s_data_i, s_ack_i       slave response
//   timeout_o               one-cycle pulse when a slave ack wait is abandoned
//
// Optional feature: define WB_ARB_TIMEOUT_EN to abandon a transfer after
// TIMEOUT_CYCLES busy cycles without ack; the master then gets ERR_DATA.
// Without the macro BUSY waits forever and timeout_o is tied low.

module wb_dual_master_arbiter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,

    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t                  state_q;
    state_t                  state_d;
    logic                    last_grant_q;   // master granted most recently; also the current owner
    logic                    req0;
    logic                    req1;
    logic                    grant_vld;
    logic                    grant_sel;
    logic                    xfer_done;
    logic                    to_hit;
    logic [CNT_W-1:0]        to_cnt_q;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Ack has priority: a timeout is only declared on a busy cycle with no ack.
    assign to_hit  = TIMEOUT_EN && (state_q == ST_BUSY) && !s_ack_i && (to_cnt_q == CNT_LAST);
    assign rd_word = to_hit ? ERR_DATA : s_data_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        xfer_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_vld = 1'b1;
                    // Under contention the master that did not win last time goes next.
                    grant_sel = (req0 && req1) ? ~last_grant_q : req1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ack_i || to_hit) begin
                    xfer_done = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            // The acked master still shows stb this cycle, so nothing is
            // arbitrated here; the next IDLE sees only genuine requests.
            ST_ACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slave-side request and master-side response registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;   // so m0 wins the first contended grant
            s_cyc_o      <= 1'b0;
            s_stb_o      <= 1'b0;
            s_we_o       <= 1'b0;
            s_sel_o      <= '0;
            s_addr_o     <= '0;
            s_data_o     <= '0;
            m0_ack_o     <= 1'b0;
            m1_ack_o     <= 1'b0;
            m0_data_o    <= '0;
            m1_data_o    <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;

            if (grant_vld) begin
                last_grant_q <= grant_sel;
                s_cyc_o      <= 1'b1;
                s_stb_o      <= 1'b1;
                s_we_o       <= grant_sel ? m1_we_i   : m0_we_i;
                s_sel_o      <= grant_sel ? m1_sel_i  : m0_sel_i;
                s_addr_o     <= grant_sel ? m1_addr_i : m0_addr_i;
                s_data_o     <= grant_sel ? m1_data_i : m0_data_i;
            end

            // Completes even if the owner has dropped cyc in the meantime.
            if (xfer_done) begin
                s_cyc_o <= 1'b0;
                s_stb_o <= 1'b0;
                if (last_grant_q) begin
                    m1_ack_o  <= 1'b1;
                    m1_data_o <= rd_word;
                end else begin
                    m0_ack_o  <= 1'b1;
                    m0_data_o <= rd_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Slave ack watchdog
    // ------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (grant_vld) begin
                to_cnt_q <= '0;
            end else if ((state_q == ST_BUSY) && !s_ack_i) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_cnt_q  = '0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench for wb_dual_master_arbiter: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a transfer-level reference model.
// Masters and the slave are bench agents driven one cycle at a time.

module tb_wb_dual_master_arbiter;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
    } tx_t;

    logic        sys_clk;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;

    wb_dual_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .timeout_o(timeout_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Agents
    tx_t         q0[$];
    tx_t         q1[$];
    bit          pres[2];
    int          gap[2];
    int          gap_max;
    bit          scramble0;
    bit          abandon1;
    int          sl_wait, sl_target, sl_min, sl_max;
    bit          stray_en;
    logic [31:0] sl_data_q[$];

    // Reference model: one transfer in flight, a one-cycle ack gap after it
    bit          mx_active;
    bit          mx_ackcyc;
    int          mx_owner;
    int          mx_last;
    int          mx_busy;
    tx_t         mx_tx;
    logic [31:0] e_data[2];
    bit          e_ack[2];
    bit          e_to;

    // Observations
    int          ack_cnt[2];
    int          to_seen;
    int          ack_order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tx_t mk(input logic [31:0] a, input logic we, input logic [3:0] sel,
                               input logic [31:0] d);
        tx_t t;
        t.addr = a; t.we = we; t.sel = sel; t.data = d;
        return t;
    endfunction

    function automatic tx_t rnd_tx();
        return mk($urandom, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom);
    endfunction

    function automatic int pick();
        return int'($urandom_range(sl_max, sl_min));
    endfunction

    task automatic model_reset();
        mx_active = 0; mx_ackcyc = 0; mx_owner = 0; mx_last = 1; mx_busy = 0;
        mx_tx = '0;
        e_data[0] = '0; e_data[1] = '0;
        e_ack[0] = 0; e_ack[1] = 0; e_to = 0;
    endtask

    // Advances the model across one clock edge using the inputs the bench is driving.
    task automatic model_eval();
        bit r0, r1, done;
        logic [31:0] rd;
        e_ack[0] = 0; e_ack[1] = 0; e_to = 0;
        done = 0; rd = '0;
        r0 = m0_cyc_i && m0_stb_i;
        r1 = m1_cyc_i && m1_stb_i;
        if (mx_ackcyc) begin
            mx_ackcyc = 0;
        end else if (mx_active) begin
            if (s_ack_i) begin
                done = 1; rd = s_data_i;
`ifdef WB_ARB_TIMEOUT_EN
            end else if (mx_busy == TO - 1) begin
                done = 1; rd = ERR; e_to = 1;
`endif
            end else begin
                mx_busy++;
            end
            if (done) begin
                mx_active = 0; mx_ackcyc = 1;
                e_ack[mx_owner] = 1; e_data[mx_owner] = rd;
            end
        end else if (r0 || r1) begin
            if (r0 && r1) mx_owner = 1 - mx_last;
            else          mx_owner = r1 ? 1 : 0;
            mx_last = mx_owner;
            if (mx_owner == 0) mx_tx = mk(m0_addr_i, m0_we_i, m0_sel_i, m0_data_i);
            else               mx_tx = mk(m1_addr_i, m1_we_i, m1_sel_i, m1_data_i);
            mx_active = 1; mx_busy = 0;
        end
    endtask

    task automatic check_outputs();
        chk("s_cyc", s_cyc_o, mx_active);
        chk("s_stb", s_stb_o, mx_active);
        if (mx_active) begin
            chk("s_we", s_we_o, mx_tx.we);
            chk("s_sel", s_sel_o, mx_tx.sel);
            chk("s_addr", s_addr_o, mx_tx.addr);
            chk("s_wdata", s_data_o, mx_tx.data);
        end
        chk("m0_ack", m0_ack_o, e_ack[0]);
        chk("m1_ack", m1_ack_o, e_ack[1]);
        chk("m0_rdata", m0_data_o, e_data[0]);
        chk("m1_rdata", m1_data_o, e_data[1]);
        chk("timeout", timeout_o, e_to);
        if (m0_ack_o === 1'b1) begin ack_cnt[0]++; ack_order.push_back(0); end
        if (m1_ack_o === 1'b1) begin ack_cnt[1]++; ack_order.push_back(1); end
        if (timeout_o === 1'b1) to_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_cyc"}, s_cyc_o, 0);
        chk({tag, "_s_stb"}, s_stb_o, 0);
        chk({tag, "_s_we"}, s_we_o, 0);
        chk({tag, "_s_sel"}, s_sel_o, 0);
        chk({tag, "_s_addr"}, s_addr_o, 0);
        chk({tag, "_s_wdata"}, s_data_o, 0);
        chk({tag, "_m0_ack"}, m0_ack_o, 0);
        chk({tag, "_m1_ack"}, m1_ack_o, 0);
        chk({tag, "_m0_rdata"}, m0_data_o, 0);
        chk({tag, "_m1_rdata"}, m1_data_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
    endtask

    task automatic drive_m(input int n, input bit on, input tx_t t);
        if (n == 0) begin
            m0_cyc_i = on; m0_stb_i = on; m0_we_i = t.we;
            m0_sel_i = t.sel; m0_addr_i = t.addr; m0_data_i = t.data;
        end else begin
            m1_cyc_i = on; m1_stb_i = on; m1_we_i = t.we;
            m1_sel_i = t.sel; m1_addr_i = t.addr; m1_data_i = t.data;
        end
    endtask

    task automatic agent_master(input int n);
        tx_t t;
        bit  acked;
        int  depth;
        t = '0;
        acked = (n == 0) ? (m0_ack_o === 1'b1) : (m1_ack_o === 1'b1);
        if (acked && pres[n]) begin
            if (n == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            pres[n] = 0;
            drive_m(n, 0, t);
            gap[n] = int'($urandom_range(gap_max, 0));
        end else if (pres[n] && mx_active && mx_owner == n) begin
            if (n == 0 && scramble0) m0_addr_i = $urandom;
            if (n == 1 && abandon1) begin m1_cyc_i = 0; m1_stb_i = 0; end
        end
        depth = (n == 0) ? q0.size() : q1.size();
        if (!pres[n] && depth > 0) begin
            if (gap[n] == 0) begin
                t = (n == 0) ? q0[0] : q1[0];
                drive_m(n, 1, t);
                pres[n] = 1;
            end else begin
                gap[n]--;
            end
        end
    endtask

    task automatic agent_slave();
        s_ack_i = 1'b0;
        if (s_stb_o === 1'b1) begin
            if (sl_wait >= sl_target) begin
                s_ack_i = 1'b1;
                if (sl_data_q.size() > 0) s_data_i = sl_data_q.pop_front();
                else                      s_data_i = $urandom;
                sl_wait = 0;
                sl_target = pick();
            end else begin
                sl_wait++;
            end
        end else begin
            if (sl_wait != 0) begin sl_wait = 0; sl_target = pick(); end
            if (stray_en && $urandom_range(7, 0) == 0) begin
                s_ack_i = 1'b1; s_data_i = $urandom;
            end
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge sys_clk);
        #1;
        check_outputs();
        agent_master(0);
        agent_master(1);
        agent_slave();
    endtask

    task automatic drain(input int budget, input string tag);
        tx_t z;
        z = '0;
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            step();
        end
        chk(tag, q0.size() + q1.size(), 0);
        if (q0.size() + q1.size() != 0) begin
            q0.delete(); q1.delete();
            pres[0] = 0; pres[1] = 0;
            drive_m(0, 0, z); drive_m(1, 0, z);
        end
        step();
        step();
    endtask

    // Asserts reset between clock edges while a transfer is in flight.
    task automatic do_reset_mid();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        model_reset();
        s_ack_i = 1'b0;
        sl_wait = 0;
        sl_target = pick();
        @(posedge sys_clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        ack_cnt[0] = 0; ack_cnt[1] = 0; to_seen = 0;
        ack_order.delete();
    endtask

    initial begin
        int alt_bad;
        tx_t z;
        z = '0;
        drive_m(0, 0, z); drive_m(1, 0, z);
        s_ack_i = 1'b0; s_data_i = '0;
        pres[0] = 0; pres[1] = 0; gap[0] = 0; gap[1] = 0;
        gap_max = 0; scramble0 = 0; abandon1 = 0;
        sl_wait = 0; sl_target = 0; sl_min = 0; sl_max = 2; stray_en = 0;
        model_reset();
        clear_obs();

        // Power-on reset
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst0");
        repeat (2) @(posedge sys_clk);
        #3 rst_n = 1'b1;
        step();
        step();

        // Reset in the middle of an m1 transfer; m0 must win right after release
        sl_target = 10;
        q1.push_back(mk(32'h0000_0600, 1'b0, 4'hF, 32'h0));
        for (int i = 0; i < 8 && s_stb_o !== 1'b1; i++) step();
        chk("t1_busy_before_reset", s_stb_o, 1);
        q0.push_back(mk(32'h0000_0700, 1'b0, 4'hF, 32'h0));
        step();
        step();
        do_reset_mid();
        clear_obs();
        drain(60, "t1_drain");
        chk("t1_acks", ack_order.size(), 2);
        chk("t1_first_m0", ack_order[0], 0);

        // Simultaneous requests: m0 then m1's write
        clear_obs();
        q0.push_back(mk(32'h0000_0300, 1'b0, 4'hF, 32'h0));
        q1.push_back(mk(32'h0000_0200, 1'b1, 4'b0011, 32'hCAFE_F00D));
        drain(40, "t3_drain");
        chk("t3_acks", ack_order.size(), 2);
        chk("t3_first", ack_order[0], 0);
        chk("t3_second", ack_order[1], 1);

        // m0 alone, slave answers one cycle after stb
        clear_obs();
        sl_target = 1;
        sl_data_q.push_back(32'h1234_5678);
        q0.push_back(mk(32'h0000_0100, 1'b0, 4'hF, 32'h0));
        drain(20, "t2_drain");
        chk("t2_m0_acks", ack_cnt[0], 1);
        chk("t2_m1_acks", ack_cnt[1], 0);
        chk("t2_m0_data", m0_data_o, 32'h1234_5678);

        // Continuous contention with a zero-wait slave
        clear_obs();
        sl_min = 0; sl_max = 0; sl_target = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rnd_tx());
            q1.push_back(rnd_tx());
        end
        drain(60, "t4_drain");
        chk("t4_m0_acks", ack_cnt[0], 4);
        chk("t4_m1_acks", ack_cnt[1], 4);
        alt_bad = 0;
        for (int i = 1; i < ack_order.size(); i++)
            if (ack_order[i] == ack_order[i-1]) alt_bad++;
        chk("t4_alternation", alt_bad, 0);
        sl_max = 2;

        // Slow slave while m0 illegally changes its address
        clear_obs();
        sl_target = 5;
        scramble0 = 1;
        q0.push_back(mk(32'h0000_0400, 1'b0, 4'hF, 32'h0));
        drain(30, "t5_drain");
        scramble0 = 0;
        chk("t5_m0_acks", ack_cnt[0], 1);

        // m1 drops cyc mid-transfer; the ack still arrives
        clear_obs();
        sl_target = 3;
        abandon1 = 1;
        q1.push_back(mk(32'h0000_0500, 1'b1, 4'hC, 32'h5555_AAAA));
        drain(30, "drop_drain");
        abandon1 = 0;
        chk("drop_m1_acks", ack_cnt[1], 1);

        // Long stall (beyond the watchdog limit when it is compiled in)
        clear_obs();
        sl_target = 40;
        q0.push_back(mk(32'h0000_0800, 1'b0, 4'hF, 32'h0));
        drain(80, "stall_drain");
`ifdef WB_ARB_TIMEOUT_EN
        chk("stall_timeouts", to_seen, 1);
        chk("stall_m0_data", m0_data_o, ERR);

        // Slave never answers m1, then a normal transfer follows
        clear_obs();
        sl_target = 1000;
        q1.push_back(mk(32'h0000_0900, 1'b0, 4'hF, 32'h0));
        drain(40, "t6_drain");
        chk("t6_timeouts", to_seen, 1);
        chk("t6_m1_data", m1_data_o, ERR);
        q0.push_back(mk(32'h0000_0A00, 1'b0, 4'hF, 32'h0));
        drain(20, "t6_next_drain");
        chk("t6_next_m0_acks", ack_cnt[0], 1);

        // Ack on the very last allowed busy cycle beats the timeout
        clear_obs();
        sl_target = TO - 1;
        q0.push_back(mk(32'h0000_0B00, 1'b0, 4'hF, 32'h0));
        drain(40, "t6_edge_drain");
        chk("t6_edge_timeouts", to_seen, 0);
`else
        chk("stall_timeouts", to_seen, 0);
        chk("stall_m0_acks", ack_cnt[0], 1);
`endif

        // Randomized traffic with gaps, variable slave wait and stray acks
        clear_obs();
        gap_max = 3; sl_min = 0; sl_max = 4; stray_en = 1;
        for (int i = 0; i < 20; i++) begin
            q0.push_back(rnd_tx());
            q1.push_back(rnd_tx());
        end
        drain(1500, "rand_drain");
        stray_en = 0;
        chk("rand_m0_acks", ack_cnt[0], 20);
        chk("rand_m1_acks", ack_cnt[1], 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
